// File: rtl/nuc970_ecc_pkg.sv
// Shared helpers, default geometry, FSM encodings and the status record for the
// nuc970 BCH error-correction stage.
package nuc970_ecc_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    localparam int unsigned DATA_BITS_DEF = 4288;
    localparam int unsigned BITS_DEF      = 8;
    localparam int unsigned NSECT_DEF     = 2;
    localparam int unsigned T_DEF         = 4;

    localparam int unsigned W     = ceil_div(DATA_BITS_DEF, BITS_DEF);
    localparam int unsigned CNT_W = clog2(T_DEF + 1);

    typedef enum logic {
        CapIdle,
        CapRun
    } cap_state_e;

    // CorSkip swallows an error stream up to its last word (underflow, or a
    // stream that runs past the sector length).
    typedef enum logic [1:0] {
        CorIdle,
        CorRun,
        CorSkip
    } cor_state_e;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             uncorr;
    } stat_t;

endpackage

// File: rtl/nuc970_sect_buf.sv
// Sector buffer: simple dual-port RAM, synchronous write, combinational read so
// the corrector can stream one word per cycle without a prefetch stage.
module nuc970_sect_buf
    import nuc970_ecc_pkg::*;
#(
    parameter int unsigned BITS  = 8,
    parameter int unsigned DEPTH = 1072,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic            clk_in,
    input  logic            we_in,
    input  logic [AW-1:0]   waddr_in,
    input  logic [BITS-1:0] wdata_in,
    input  logic [AW-1:0]   raddr_in,
    output logic [BITS-1:0] rdata_out
);

    logic [BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we_in) mem[waddr_in] <= wdata_in;
    end

    assign rdata_out = mem[raddr_in];

endmodule

// File: rtl/nuc970_err_correct.sv
// Stream error corrector behind the nuc970 BCH decoder: buffers raw sectors, XORs in the
// decoder's error mask and reports per-sector status. Error-position log: NUC970_ERR_LOG_EN.
module nuc970_err_correct
    import nuc970_ecc_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF,
    parameter int unsigned BITS      = BITS_DEF,
    parameter int unsigned NSECT     = NSECT_DEF,
    parameter int unsigned T         = T_DEF,
`ifdef NUC970_ERR_LOG_EN
    parameter int unsigned LOG_DEPTH = 4,
    localparam int unsigned LIW      = (LOG_DEPTH > 1) ? clog2(LOG_DEPTH) : 1,
`endif
    localparam int unsigned CW       = clog2(T + 1)
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [BITS-1:0] data_in,
    input  logic            start_in,
    input  logic [BITS-1:0] err_in,
    input  logic            err_first_in,
    input  logic            err_valid_in,
    input  logic            err_last_in,
    input  logic [7:0]      err_cnt_in,
    output logic [BITS-1:0] data_out,
    output logic            valid_out,
    output logic            first_out,
    output logic            last_out,
    output logic            stat_valid_out,
    output logic [CW-1:0]   stat_cnt_out,
    output logic            stat_uncorr_out,
    output logic            ovf_out,
    output logic            unf_out
`ifdef NUC970_ERR_LOG_EN
    ,
    output logic            log_valid_out,
    input  logic [LIW-1:0]  log_idx_in,
    output logic [15:0]     log_pos_out
`endif
);

    localparam int unsigned WORDS = ceil_div(DATA_BITS, BITS);
    localparam int unsigned DEPTH = NSECT * WORDS;
    localparam int unsigned AW    = clog2(DEPTH);
    localparam int unsigned OFW   = clog2(WORDS);
    localparam int unsigned PW    = (NSECT > 1) ? clog2(NSECT) : 1;
    localparam int unsigned OCW   = clog2(NSECT + 1);

    localparam logic [OFW-1:0] LAST_OFS = OFW'(WORDS - 1);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    cap_state_e cap_q, cap_d;
    cor_state_e cor_q, cor_d;

    logic [OFW-1:0]  wcnt_q, wcnt_d, rcnt_q, rcnt_d, rcnt_eff, buf_wofs;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCW-1:0]  occ_q, occ_d;
    logic [7:0]      ecnt_q, ecnt_d, ecnt_eff;
    logic [CW-1:0]   pop_q, pop_d, pop_eff, pop_new;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic [BITS-1:0] data_q, data_d;
    logic            valid_q, valid_d, first_q, first_d, last_q, last_d;
    logic            pend_q, pend_d, stat_valid_q;
    stat_t           stat_q, stat_d;

    logic            buf_we, cap_done;
    logic [AW-1:0]   buf_waddr, buf_raddr;
    logic [BITS-1:0] buf_rdata;
    logic            enter, take, at_end, close;
    int unsigned     pc, sum;

    nuc970_sect_buf #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_in    (clk_in),
        .we_in     (buf_we),
        .waddr_in  (buf_waddr),
        .wdata_in  (data_in),
        .raddr_in  (buf_raddr),
        .rdata_out (buf_rdata)
    );

    // Capture side: one sector slot at a time, only into a free slot.
    always_comb begin
        cap_d    = cap_q;
        wcnt_d   = wcnt_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        buf_we   = 1'b0;
        buf_wofs = wcnt_q;
        cap_done = 1'b0;
        unique case (cap_q)
            CapIdle: begin
                if (start_in) begin
                    if (occ_q < OCW'(NSECT)) begin
                        buf_we   = 1'b1;
                        buf_wofs = '0;
                        wcnt_d   = OFW'(1);
                        cap_d    = CapRun;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            CapRun: begin
                buf_we = 1'b1;
                if (start_in) begin
                    buf_wofs = '0;
                    wcnt_d   = OFW'(1);
                end else if (wcnt_q == LAST_OFS) begin
                    cap_done = 1'b1;
                    cap_d    = CapIdle;
                    wr_ptr_d = (wr_ptr_q == PW'(NSECT - 1)) ? '0 : wr_ptr_q + 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: cap_d = CapIdle;
        endcase
        buf_waddr = AW'(wr_ptr_q) * AW'(WORDS) + AW'(buf_wofs);
    end

    // Correction side: first word is served in the same cycle the stream opens.
    always_comb begin
        enter    = (cor_q == CorIdle) && err_first_in && ((occ_q != '0) || cap_done);
        take     = ((cor_q == CorRun) || enter) && err_valid_in;
        rcnt_eff = (cor_q == CorRun) ? rcnt_q : '0;
        ecnt_eff = enter ? err_cnt_in : ecnt_q;
        pop_eff  = enter ? '0 : pop_q;
        at_end   = (rcnt_eff == LAST_OFS);
        close    = take && (err_last_in || at_end);
        buf_raddr = AW'(rd_ptr_q) * AW'(WORDS) + AW'(rcnt_eff);

        pc = 0;
        for (int unsigned i = 0; i < BITS; i++) pc += 32'(err_in[i]);
        sum     = 32'(pop_eff) + pc;
        pop_new = (sum > 32'(CNT_MAX)) ? CNT_MAX : CW'(sum);

        cor_d    = cor_q;
        rcnt_d   = rcnt_q;
        ecnt_d   = ecnt_q;
        pop_d    = pop_q;
        rd_ptr_d = rd_ptr_q;
        unf_d    = unf_q;
        unique case (cor_q)
            CorIdle: begin
                if (enter) begin
                    cor_d  = CorRun;
                    ecnt_d = err_cnt_in;
                    pop_d  = '0;
                    rcnt_d = '0;
                end else if (err_first_in) begin
                    unf_d = 1'b1;
                    if (!(err_valid_in && err_last_in)) cor_d = CorSkip;
                end
            end
            CorRun: ;
            CorSkip: begin
                if (err_valid_in && err_last_in) cor_d = CorIdle;
            end
            default: cor_d = CorIdle;
        endcase
        if (take) begin
            pop_d  = pop_new;
            rcnt_d = rcnt_eff + 1'b1;
        end
        if (close) begin
            cor_d    = err_last_in ? CorIdle : CorSkip;
            rd_ptr_d = (rd_ptr_q == PW'(NSECT - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        valid_d = take;
        first_d = take && (rcnt_eff == '0);
        last_d  = close;
        data_d  = take ? (buf_rdata ^ err_in) : '0;

        pend_d = close;
        stat_d = stat_q;
        if (close) begin
            stat_d.cnt    = CNT_W'(pop_new);
            stat_d.uncorr = (8'(pop_new) != ecnt_eff) || (ecnt_eff > 8'(T)) ||
                            (err_last_in && !at_end);
        end

        unique case ({cap_done, close})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cap_q        <= CapIdle;
            cor_q        <= CorIdle;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            ecnt_q       <= '0;
            pop_q        <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            pend_q       <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_q       <= '0;
        end else begin
            cap_q        <= cap_d;
            cor_q        <= cor_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            ecnt_q       <= ecnt_d;
            pop_q        <= pop_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            pend_q       <= pend_d;
            stat_valid_q <= pend_q;
            stat_q       <= stat_d;
        end
    end

    assign data_out        = data_q;
    assign valid_out       = valid_q;
    assign first_out       = first_q;
    assign last_out        = last_q;
    assign stat_valid_out  = stat_valid_q;
    assign stat_cnt_out    = CW'(stat_q.cnt);
    assign stat_uncorr_out = stat_q.uncorr;
    assign ovf_out         = ovf_q;
    assign unf_out         = unf_q;

`ifdef NUC970_ERR_LOG_EN
    localparam int unsigned LNW = clog2(LOG_DEPTH + 1);

    logic [15:0]    log_q [LOG_DEPTH];
    logic [15:0]    log_d [LOG_DEPTH];
    logic [LNW-1:0] log_n_q, log_n_d;
    logic           log_valid_q;

    always_comb begin
        log_d   = log_q;
        log_n_d = log_n_q;
        if (enter) begin
            for (int unsigned i = 0; i < LOG_DEPTH; i++) log_d[i] = 16'hFFFF;
            log_n_d = '0;
        end
        if (take && (err_in != '0) && (32'(log_n_d) < LOG_DEPTH)) begin
            log_d[LIW'(log_n_d)] = 16'(rcnt_eff);
            log_n_d = log_n_d + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < LOG_DEPTH; i++) log_q[i] <= 16'hFFFF;
            log_n_q     <= '0;
            log_valid_q <= 1'b0;
        end else begin
            log_q       <= log_d;
            log_n_q     <= log_n_d;
            log_valid_q <= pend_q;
        end
    end

    assign log_valid_out = log_valid_q;
    assign log_pos_out   = log_q[log_idx_in];
`endif

endmodule

// File: doc/nuc970_err_correct.md
Name: nuc970_err_correct

Overview:
- Stream-level error corrector that sits directly after the nuc970 BCH decoder.
- Buffers up to NSECT raw sectors while syndrome, BMA and Chien stages run.
- XORs the decoder's error mask into the buffered data and emits corrected words.
- Emits per-sector status (error count, uncorrectable flag), plus overflow/underflow flags for the firmware-facing wrapper.

Parameters:
- DATA_BITS, 4288, data bits per sector (ECC bits excluded).
- BITS, 8, word width of the data and error streams.
- NSECT, 2, sectors buffered in flight (power of two, ≥1).
- T, 4, correction capability; sizes the count field (CNT_W = clog2(T+1)).
- LOG_DEPTH, 4, error positions logged per sector (optional feature only).

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- data_in  in  BITS  raw sector word, same stream fed to the decoder
- start_in  in  1  first word of a sector on data_in
- err_in  in  BITS  decoder error mask word
- err_first_in  in  1  first error word of a sector
- err_valid_in  in  1  error word valid
- err_last_in  in  1  last error word of a sector
- err_cnt_in  in  8  BMA error count, sampled on err_first_in
- data_out  out  BITS  corrected word
- valid_out  out  1  data_out valid
- first_out  out  1  first corrected word of a sector
- last_out  out  1  last corrected word of a sector
- stat_valid_out  out  1  one-cycle status strobe
- stat_cnt_out  out  CNT_W  errors corrected in the sector
- stat_uncorr_out  out  1  sector is uncorrectable
- ovf_out  out  1  sticky: sector dropped because the buffer was full
- unf_out  out  1  sticky: error stream arrived with no sector buffered

Behaviour:
- Reset values: all outputs 0; pointers, occupancy and the capture FSM are cleared.
- Reset is asynchronous. Asserting it mid-sector discards all buffered and in-progress sectors.
- Constant W = ceil(DATA_BITS/BITS). Buffer is NSECT*W words. Sector k occupies base k*W.
- Capture FSM, states IDLE and CAP:
  - IDLE → CAP on start_in when occupancy < NSECT. That word is written at wr_base, wcnt = 1.
  - In CAP, one word is written per cycle. At wcnt == W-1 the write completes, occupancy increments, wr_base advances mod NSECT, and the FSM returns to IDLE.
  - Trailing ECC words on data_in are ignored.
  - start_in in CAP restarts the capture at the same wr_base; the partial sector is discarded.
  - start_in when occupancy == NSECT: sector dropped, ovf_out set, FSM stays IDLE.
- Correction FSM, states IDLE and RUN:
  - err_first_in with occupancy > 0 (counting a write completing in the same cycle): enter RUN, rcnt = 0, latch err_cnt_in.
  - err_first_in with occupancy == 0: unf_out set; that sector's error stream is ignored through err_last_in.
  - Each err_valid_in cycle in RUN: read buf[rd_base+rcnt] and present data_out = word ^ err_in registered, one cycle after the err word. valid_out, first_out and last_out follow with the same 1-cycle latency. rcnt increments.
  - Buffer read is combinational or prefetched so that throughput is one word per cycle with no bubbles.
  - Popcount of err_in is accumulated saturating at 2^CNT_W-1.
  - On err_last_in: occupancy decrements and rd_base advances.
  - One cycle after last_out: stat_valid_out pulses with stat_cnt_out = popcount.
  - stat_uncorr_out = (popcount != latched err_cnt_in) OR (err_cnt_in > T).
  - err_last_in before W words: sector closes early, stat_uncorr_out forced to 1.
- Simultaneous capture completion and err_last_in: occupancy is unchanged.
- Output is not backpressured. Downstream must accept one word per cycle.

Optional Feature:
- Macro NUC970_ERR_LOG_EN.
- When defined: adds ports log_valid_out (1), log_idx_in (clog2(LOG_DEPTH)) and log_pos_out (16).
  - The first LOG_DEPTH nonzero err_in words of the current sector record their word offset rcnt.
  - log_pos_out = entry[log_idx_in]. Unused entries read 16'hFFFF.
  - The log clears on err_first_in. log_valid_out pulses together with stat_valid_out.
- When undefined: no such ports and no log storage.

Decomposition:
- Package nuc970_ecc_pkg holds:
  - functions clog2 and ceil_div, and localparams W and CNT_W;
  - capture/correction state encodings;
  - the status struct {cnt, uncorr}.
- One sub-module, nuc970_sect_buf: simple dual-port word RAM, NSECT*W x BITS, synchronous write, read as above.
- FSMs and popcount stay in the top module.

Test Plan:
- Single sector, DATA_BITS=4288, BITS=8 (W=536), error mask zero, err_cnt_in=0 → 536 valid_out words equal to the input, stat_cnt_out=0, stat_uncorr_out=0.
- err_in=8'h01 at word 0, 8'h80 at word 535, 8'h10 at word 200, err_cnt_in=3 → exactly those three bits flipped, stat_cnt_out=3, uncorr=0.
- Mask with 2 bits set but err_cnt_in=3 → stat_uncorr_out=1, data still XORed.
- NSECT=2: three start_in sectors before any err_first_in → third dropped, ovf_out=1, the two buffered sectors are output in order.
- err_first_in after reset with no data → unf_out=1, valid_out stays 0.
- rst_n_in low at word 300 of a correction → all outputs 0 immediately; after release, a new sector corrects normally.
